// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory with stall/ready handshake (ports: clk, rst_n, memread, memwrite, addr, wdata -> rdata, ready, stall, err)
module dmem_responder #(
  parameter int ADDR_W = 6,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        stall,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC == 0 ? 0 : WAIT_CYC - 1);
  state_t r_state, w_next;
  logic [3:0] r_cnt, w_cnt_next;
  logic [ADDR_W-1:0] r_idx, w_idx;
  logic [31:0] r_wdata, w_wdata, r_rdata;
  logic [31:0] r_mem [2**ADDR_W];
  logic r_rd, r_wr, r_err, w_rd, w_wr, w_err, w_req, w_idle, w_accept, w_go;
  logic w_unused;
  assign w_unused = &{1'b0, addr[31:ADDR_W+2]};
  assign w_req = memread | memwrite;
  assign w_idle = r_state == IDLE;
  assign w_accept = w_idle & w_req;
  // With WAIT_CYC=0 the array is accessed on the acceptance edge, so use live inputs in IDLE
  assign w_idx = w_idle ? addr[ADDR_W+1:2] : r_idx;
  assign w_wdata = w_idle ? wdata : r_wdata;
  assign w_rd = w_idle ? memread : r_rd;
  assign w_wr = w_idle ? memwrite : r_wr;
  assign w_err = w_idle ? (addr[1:0] != 2'b00 || (memread && memwrite)) : r_err;
  assign w_go = (w_accept && WAIT_CYC == 0) || (r_state == WAIT && r_cnt == 4'd0);
  assign stall = w_accept | (r_state == WAIT);
  assign ready = r_state == RESP;
  assign err = ready & r_err;
  assign rdata = r_rdata;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = WAIT_CYC == 0 ? RESP : WAIT;
      WAIT: if (r_cnt == 4'd0) w_next = RESP;
      default: w_next = IDLE;
    endcase
    w_cnt_next = w_accept ? CNT_INIT : (r_state == WAIT && r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_idx <= '0;
      r_wdata <= '0;
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      r_err <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt_next;
      if (w_accept) begin
        r_idx <= addr[ADDR_W+1:2];
        r_wdata <= wdata;
        r_rd <= memread;
        r_wr <= memwrite;
        r_err <= addr[1:0] != 2'b00 || (memread && memwrite);
      end
      if (w_go) r_rdata <= (w_rd && !w_err) ? r_mem[w_idx] : '0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) r_mem[i] <= '0;
    end else if (w_go && w_wr && !w_err) begin
      r_mem[w_idx] <= w_wdata;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder with WAIT_CYC=2 and WAIT_CYC=0
module tb_dmem_responder;
  logic clk = 1'b0, rst_n = 1'b0, memread = 1'b0, memwrite = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata_2, rdata_0;
  logic ready_2, stall_2, err_2, ready_0, stall_0, err_0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  dmem_responder #(.ADDR_W(6), .WAIT_CYC(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .memread(memread), .memwrite(memwrite), .addr(addr), .wdata(wdata),
    .rdata(rdata_2), .ready(ready_2), .stall(stall_2), .err(err_2));
  dmem_responder #(.ADDR_W(6), .WAIT_CYC(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .memread(memread), .memwrite(memwrite), .addr(addr), .wdata(wdata),
    .rdata(rdata_0), .ready(ready_0), .stall(stall_0), .err(err_0));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic xact(input string tag, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [31:0] er, input logic ee);
    memread = rd;
    memwrite = wr;
    addr = a;
    wdata = d;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk({tag, "_stall"}, 32'(stall_2), 32'(c < 3));
      chk({tag, "_ready"}, 32'(ready_2), 32'(c == 3));
      if (c == 3) begin
        chk({tag, "_rdata"}, rdata_2, er);
        chk({tag, "_err"}, 32'(err_2), 32'(ee));
      end
      @(posedge clk);
      #1;
    end
    memread = 1'b0;
    memwrite = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    chk("rst_ready", 32'(ready_2), 32'd0);
    chk("rst_err", 32'(err_2), 32'd0);
    chk("rst_rdata", rdata_2, 32'd0);
    chk("rst_stall", 32'(stall_2), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    xact("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    xact("wr104", 1'b0, 1'b1, 32'h104, 32'h12345678, 32'h0, 1'b0);
    xact("rd004", 1'b1, 1'b0, 32'h004, 32'h0, 32'h12345678, 1'b0);
    xact("rd13", 1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
    xact("rw20", 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1);
    xact("rd20", 1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
    memwrite = 1'b1;
    addr = 32'h08;
    wdata = 32'hAAAA5555;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_wait_stall", 32'(stall_2), 32'd1);
    #2;
    rst_n = 1'b0;
    memwrite = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall_2), 32'd0);
    chk("midrst_ready", 32'(ready_2), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("inrst_ready", 32'(ready_2), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("postrst_ready", 32'(ready_2), 32'd0);
      @(posedge clk);
      #1;
    end
    xact("rd08", 1'b1, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0);
    xact("rd10_clr", 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    memwrite = 1'b1;
    addr = 32'h10;
    wdata = 32'h5A5A0000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("b2b_wr_ready", 32'(ready_0), 32'(c % 2 == 1));
      chk("b2b_wr_stall", 32'(stall_0), 32'(c % 2 == 0));
      if (c % 2 == 1) chk("b2b_wr_rdata", rdata_0, 32'h0);
      @(posedge clk);
      #1;
    end
    memwrite = 1'b0;
    memread = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("b2b_rd_ready", 32'(ready_0), 32'(c % 2 == 1));
      chk("b2b_rd_stall", 32'(stall_0), 32'(c % 2 == 0));
      if (c % 2 == 1) begin
        chk("b2b_rd_rdata", rdata_0, 32'h5A5A0000);
        chk("b2b_rd_err", 32'(err_0), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    memread = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, giving log2 of the word count (64 words of 32 bits).
REQ-002 SHALL have parameter WAIT_CYC, default 2, giving the wait cycles between request acceptance and response (range 0-15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port memread, input, 1 bit: read request from the control decoder.
REQ-006 SHALL have port memwrite, input, 1 bit: write request from the control decoder.
REQ-007 SHALL have port addr, input, 32 bits: byte address.
REQ-008 SHALL have port wdata, input, 32 bits: write data.
REQ-009 SHALL have port rdata, output, 32 bits: registered read data, valid while ready=1.
REQ-010 SHALL have port ready, output, 1 bit: one-cycle response strobe.
REQ-011 SHALL have port stall, output, 1 bit: freezes the requesting datapath.
REQ-012 SHALL have port err, output, 1 bit: error flag, valid while ready=1.

Function
REQ-013 SHALL implement a storage array of 2^ADDR_W words of 32 bits, indexed by addr[ADDR_W+1:2]; addr[31:ADDR_W+2] ignored (aliasing wrap-around).
REQ-014 SHALL implement the FSM states IDLE, WAIT, RESP.
REQ-015 SHALL treat a request as present when memread=1 or memwrite=1.
REQ-016 IDLE, request present: SHALL latch addr, wdata, request type and error condition at the edge, then go to WAIT with counter=WAIT_CYC-1, or directly to RESP if WAIT_CYC=0.
REQ-017 WAIT: SHALL decrement the counter each edge and go to RESP on the edge where the counter equals 0.
REQ-018 RESP: SHALL assert ready for exactly one cycle, then return to IDLE unconditionally.
REQ-019 Latency: for a request accepted at the edge ending cycle N, ready SHALL be high in cycle N+1+WAIT_CYC.
REQ-020 IDLE to IDLE: SHALL insert a mandatory 1-cycle gap after RESP; a request held into that cycle is accepted as a new request.
REQ-021 SHALL drive stall combinationally: stall = (IDLE and request present) or WAIT; stall SHALL be 0 in RESP.
REQ-022 The requester SHALL hold memread, memwrite, addr and wdata stable while stall=1; the block samples them only at acceptance.
REQ-023 Read: SHALL load rdata from the array on the edge entering RESP, and hold that value until the next response.
REQ-024 Write: SHALL update the array on the edge entering RESP; rdata SHALL be 0 for a write response.
REQ-025 Error: when addr[1:0]!=0, or memread and memwrite are both 1, SHALL set err=1 in RESP, perform no array access, and drive rdata=0.
REQ-026 err SHALL be 0 whenever ready=0.
REQ-027 A read to a word written by the previous transaction SHALL return the new data.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, counter 0, rdata 0, ready 0, err 0, and clear all array words to 0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no array write; after rst_n rises, stall follows REQ-021 from IDLE.
REQ-030 Deassertion of rst_n SHALL be synchronised by the integrator; no request is accepted in the cycle in which rst_n is low.

Verification
REQ-031 Write then read, WAIT_CYC=2: write 0xDEADBEEF to addr 0x10 -> ready in cycle 3, stall high in cycles 0-2; then read 0x10 -> rdata=0xDEADBEEF, err=0.
REQ-032 Aliasing: write 0x12345678 to 0x104 -> a read of 0x004 returns 0x12345678 (ADDR_W=6).
REQ-033 Errors: read 0x13 -> ready with err=1, rdata=0; memread and memwrite both 1 at 0x20 with wdata 0xFFFFFFFF -> err=1, and a later read of 0x20 returns 0.
REQ-034 Reset mid-write: assert rst_n=0 during WAIT of a write of 0xAAAA5555 to 0x08 -> ready never pulses, and a read of 0x08 after reset returns 0.
REQ-035 Back-to-back, WAIT_CYC=0: request held continuously -> ready high every second cycle, stall=0 in each RESP cycle, with exactly one gap cycle between responses.
